t05_sram_arbiter: RTL and testbench
===================================

Name: t05_sram_arbiter

Overview:
- Shares the single-port histogram/frequency SRAM among NREQ requesters in the compression pipeline: histogram, sorter/tree builder, codebook generator.
- One transaction in flight at a time. Per-requester req/we/addr/wdata in, gnt/done/rdata out.
- Sequences the SRAM enable, write strobe and fixed read latency, so requesters no longer drive SRAM control codes themselves.

Parameters:
- NREQ, 3, number of requesters; index 0 is the histogram.
- AW, 8, SRAM address width.
- DW, 32, SRAM data width.
- RD_LAT, 2, cycles from the read-issue cycle to sram_rdata valid; must be 1 or more.

Ports:
- clk  input  1  system clock
- rst  input  1  reset; synchronous, active-high
- req  input  NREQ  per-requester request level
- we  input  NREQ  per-requester op: 1 = write, 0 = read
- addr  input  NREQ*AW  packed addresses; requester i uses bits [i*AW +: AW]
- wdata  input  NREQ*DW  packed write data; requester i uses bits [i*DW +: DW]
- gnt  output  NREQ  one-hot grant, held for the whole transaction
- done  output  NREQ  one-hot, 1-cycle completion pulse
- rdata  output  DW  registered read data; valid while done is high for a read
- sram_en  output  1  SRAM access strobe
- sram_we  output  1  SRAM write strobe
- sram_addr  output  AW  SRAM address
- sram_wdata  output  DW  SRAM write data
- sram_rdata  input  DW  SRAM read data, valid RD_LAT cycles after issue

Behaviour:
- Reset (rst=1 at a clk edge, any state) sets:
  - state IDLE, rr_ptr 0, wait counter 0
  - gnt, done, rdata, sram_en, sram_we, sram_addr, sram_wdata all 0
  - a transaction in progress is abandoned with no done pulse
- States: IDLE, ISSUE, WAIT, RESP.
- IDLE:
  - If any req is high, pick a winner by round-robin: the first set bit scanning rr_ptr, rr_ptr+1, ... modulo NREQ.
  - Latch winner index, we, addr and wdata; set gnt[winner]; go to ISSUE.
  - If no req is high, stay in IDLE with all strobes 0.
- ISSUE (one cycle):
  - sram_en=1; sram_we = latched we; sram_addr and sram_wdata = latched values.
  - Write goes to RESP. Read goes to WAIT with counter loaded to RD_LAT.
- WAIT:
  - sram_en=0, sram_we=0; counter decrements each cycle.
  - On the cycle the counter reaches 1, capture sram_rdata into rdata and go to RESP.
  - WAIT lasts exactly RD_LAT cycles.
- RESP (one cycle):
  - done[winner]=1 and gnt[winner] still 1.
  - rdata is unchanged for writes.
  - rr_ptr <= (winner+1) mod NREQ; then IDLE, where gnt clears.
- Latency:
  - Write: issue 1 cycle after IDLE arbitration; done 1 cycle after issue.
  - Read: done RD_LAT+1 cycles after issue.
  - Minimum period between back-to-back grants is 3 cycles for a write and RD_LAT+3 for a read.
- Requesters hold req, we, addr and wdata stable from assertion until done. The arbiter samples them only in IDLE.
- If req drops mid-transaction, the transaction still completes and done still pulses.
- If the winner keeps req high after done, it re-competes in the next IDLE behind the other requesters under round-robin.
- sram_addr and sram_wdata hold their last issued values outside ISSUE. sram_en and sram_we are 1 only in ISSUE.
- gnt and done are never multi-hot.

Optional Feature:
- Macro: T05_ARB_FIXED_PRIO_EN.
- Defined: strict fixed priority, lowest index wins in IDLE; rr_ptr is not used or updated. The histogram, at index 0, is never starved.
- Undefined: round-robin as described above.

Test Plan:
- Write: req[0]=1, we=1, addr=0x41, wdata=5 at cycle 0.
  - Cycle 1: sram_en=1, sram_we=1, sram_addr=0x41, sram_wdata=5, gnt=3'b001.
  - Cycle 2: done=3'b001.
  - Cycle 3: gnt=0.
- Read: req[1]=1, we=0, addr=0x1A at cycle 0; bench drives sram_rdata=7 in cycle 3.
  - Cycle 1: sram_en=1, sram_we=0.
  - Cycle 4: done=3'b010 and rdata=7.
- Contention: req=3'b111 held, all writes, from reset.
  - Grants in order 0,1,2,0, with done pulses at cycles 2, 5, 8, 11.
  - With T05_ARB_FIXED_PRIO_EN: 0,0,0,0.
- Reset mid-read: rst=1 during WAIT of a read.
  - Next cycle: all outputs 0 and no done pulse.
  - The subsequent request from requester 1 is granted first.
- Dropped request: req[2] deasserted in the ISSUE cycle of a read.
  - done[2] still pulses RD_LAT+1 cycles after issue.
  - Arbiter returns to IDLE and idles with no further grant.
- Wrap: rr_ptr=2 after serving 1, req=3'b011 → requester 0 is granted before requester 1.

Source files
------------

// File: rtl/t05_sram_arbiter.sv
// Arbiter for the shared histogram/frequency SRAM: one transaction in flight, fixed read latency.
// Define T05_ARB_FIXED_PRIO_EN for strict fixed priority (index 0 highest) instead of round-robin.
module t05_sram_arbiter #(
  parameter int unsigned NREQ   = 3,
  parameter int unsigned AW     = 8,
  parameter int unsigned DW     = 32,
  parameter int unsigned RD_LAT = 2
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [NREQ-1:0]      req,
  input  logic [NREQ-1:0]      we,
  input  logic [NREQ*AW-1:0]   addr,
  input  logic [NREQ*DW-1:0]   wdata,
  output logic [NREQ-1:0]      gnt,
  output logic [NREQ-1:0]      done,
  output logic [DW-1:0]        rdata,
  output logic                 sram_en,
  output logic                 sram_we,
  output logic [AW-1:0]        sram_addr,
  output logic [DW-1:0]        sram_wdata,
  input  logic [DW-1:0]        sram_rdata
);

  localparam int unsigned IW = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam int unsigned CW = $clog2(RD_LAT + 1);

  typedef enum logic [1:0] {StIdle, StIssue, StWait, StResp} state_e;

  state_e        state;
  logic [IW-1:0] winner;
  logic          op_we;
  logic [CW-1:0] wait_cnt;
  logic          any_req;
  logic [IW-1:0] pick;

`ifdef T05_ARB_FIXED_PRIO_EN
  always_comb begin
    any_req = 1'b0;
    pick    = '0;
    for (int unsigned k = 0; k < NREQ; k++) begin
      if (!any_req && req[IW'(k)]) begin
        any_req = 1'b1;
        pick    = IW'(k);
      end
    end
  end
`else
  logic [IW-1:0] rr_ptr;

  // First requester at or after rr_ptr, wrapping modulo NREQ.
  always_comb begin
    logic [IW-1:0] idx;
    any_req = 1'b0;
    pick    = '0;
    idx     = '0;
    for (int unsigned k = 0; k < NREQ; k++) begin
      idx = IW'((32'(rr_ptr) + k) % NREQ);
      if (!any_req && req[idx]) begin
        any_req = 1'b1;
        pick    = idx;
      end
    end
  end
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= StIdle;
      winner     <= '0;
      op_we      <= 1'b0;
      wait_cnt   <= '0;
      gnt        <= '0;
      done       <= '0;
      rdata      <= '0;
      sram_en    <= 1'b0;
      sram_we    <= 1'b0;
      sram_addr  <= '0;
      sram_wdata <= '0;
`ifndef T05_ARB_FIXED_PRIO_EN
      rr_ptr     <= '0;
`endif
    end else begin
      done <= '0;
      unique case (state)
        StIdle: begin
          if (any_req) begin
            winner     <= pick;
            op_we      <= we[pick];
            gnt        <= NREQ'(1) << pick;
            sram_en    <= 1'b1;
            sram_we    <= we[pick];
            sram_addr  <= addr[pick*AW +: AW];
            sram_wdata <= wdata[pick*DW +: DW];
            state      <= StIssue;
          end
        end
        StIssue: begin
          sram_en <= 1'b0;
          sram_we <= 1'b0;
          if (op_we) begin
            done  <= gnt;
            state <= StResp;
          end else begin
            wait_cnt <= CW'(RD_LAT);
            state    <= StWait;
          end
        end
        StWait: begin
          wait_cnt <= wait_cnt - 1'b1;
          // Last WAIT cycle is the one where sram_rdata is valid.
          if (wait_cnt == CW'(1)) begin
            rdata <= sram_rdata;
            done  <= gnt;
            state <= StResp;
          end
        end
        StResp: begin
          gnt   <= '0;
`ifndef T05_ARB_FIXED_PRIO_EN
          rr_ptr <= (winner == IW'(NREQ - 1)) ? '0 : winner + 1'b1;
`endif
          state <= StIdle;
        end
        default: state <= StIdle;
      endcase
    end
  end

endmodule

// File: tb/tb_t05_sram_arbiter.sv
// Directed bench for t05_sram_arbiter: completions checked by a scoreboard monitor.
module tb_t05_sram_arbiter;

  localparam int NREQ   = 3;
  localparam int AW     = 8;
  localparam int DW     = 32;
  localparam int RD_LAT = 2;

  logic               clk = 1'b0;
  logic               rst = 1'b1;
  logic [NREQ-1:0]    req = '0;
  logic [NREQ-1:0]    we = '0;
  logic [NREQ*AW-1:0] addr = '0;
  logic [NREQ*DW-1:0] wdata = '0;
  logic [DW-1:0]      sram_rdata = '0;
  logic [NREQ-1:0]    gnt;
  logic [NREQ-1:0]    done;
  logic [DW-1:0]      rdata;
  logic               sram_en;
  logic               sram_we;
  logic [AW-1:0]      sram_addr;
  logic [DW-1:0]      sram_wdata;

  int tests = 0;
  int fails = 0;
  int cyc = 0;
  int c0;
  int c1;

  typedef struct {
    logic [NREQ-1:0] done;
    logic [DW-1:0]   rdata;
    int              cyc;
  } exp_t;

  exp_t exp_q[$];

  t05_sram_arbiter #(
    .NREQ   (NREQ),
    .AW     (AW),
    .DW     (DW),
    .RD_LAT (RD_LAT)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .req        (req),
    .we         (we),
    .addr       (addr),
    .wdata      (wdata),
    .gnt        (gnt),
    .done       (done),
    .rdata      (rdata),
    .sram_en    (sram_en),
    .sram_we    (sram_we),
    .sram_addr  (sram_addr),
    .sram_wdata (sram_wdata),
    .sram_rdata (sram_rdata)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp_v);
    tests++;
    if (act !== exp_v) begin
      fails++;
      $display("FAIL %s: got 0x%0h, required 0x%0h (cycle %0d)", name, act, exp_v, cyc);
    end
  endtask

  task automatic push(input logic [NREQ-1:0] d, input logic [DW-1:0] r, input int c);
    exp_t e;
    e.done  = d;
    e.rdata = r;
    e.cyc   = c;
    exp_q.push_back(e);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Monitor: every done pulse must match the head of the scoreboard.
  always @(negedge clk) begin : mon
    exp_t e;
    if (!rst) begin
      if (gnt != '0) chk("gnt_onehot", 32'($onehot(gnt)), 32'd1);
      if (done != '0) begin
        chk("done_onehot", 32'($onehot(done)), 32'd1);
        if (exp_q.size() == 0) begin
          tests++;
          fails++;
          $display("FAIL unexpected_done: got done=%b, required no done (cycle %0d)", done, cyc);
        end else begin
          e = exp_q.pop_front();
          chk("done_vec", 32'(done), 32'(e.done));
          chk("done_cycle", 32'(cyc), 32'(e.cyc));
          chk("done_gnt", 32'(gnt), 32'(e.done));
          chk("done_rdata", rdata, e.rdata);
        end
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, required finish by 100000");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1;
    step();
    step();
    chk("rst_gnt", 32'(gnt), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_rdata", rdata, 32'd0);
    chk("rst_sram_en", 32'(sram_en), 32'd0);
    chk("rst_sram_we", 32'(sram_we), 32'd0);
    chk("rst_sram_addr", 32'(sram_addr), 32'd0);
    chk("rst_sram_wdata", sram_wdata, 32'd0);
    rst = 1'b0;

    // Write from requester 0
    c0 = cyc;
    req = 3'b001; we = 3'b001; addr[7:0] = 8'h41; wdata[31:0] = 32'd5;
    push(3'b001, 32'd0, c0 + 2);
    step();
    chk("wr_sram_en", 32'(sram_en), 32'd1);
    chk("wr_sram_we", 32'(sram_we), 32'd1);
    chk("wr_sram_addr", 32'(sram_addr), 32'h41);
    chk("wr_sram_wdata", sram_wdata, 32'd5);
    chk("wr_gnt", 32'(gnt), 32'b001);
    step();
    req = '0;
    step();
    chk("wr_gnt_clear", 32'(gnt), 32'd0);
    chk("wr_en_idle", 32'(sram_en), 32'd0);
    chk("wr_addr_hold", 32'(sram_addr), 32'h41);

    // Read from requester 1
    c0 = cyc;
    req = 3'b010; we = 3'b000; addr[15:8] = 8'h1A;
    push(3'b010, 32'd7, c0 + 4);
    step();
    chk("rd_sram_en", 32'(sram_en), 32'd1);
    chk("rd_sram_we", 32'(sram_we), 32'd0);
    chk("rd_sram_addr", 32'(sram_addr), 32'h1A);
    chk("rd_gnt", 32'(gnt), 32'b010);
    step();
    chk("rd_wait_en", 32'(sram_en), 32'd0);
    step();
    sram_rdata = 32'd7;
    step();
    sram_rdata = 32'hDEADBEEF;
    req = '0;
    step();
    chk("rd_gnt_clear", 32'(gnt), 32'd0);

    // Wrap: rr_ptr is 2, so requester 0 goes before requester 1
    c0 = cyc;
    req = 3'b011; we = 3'b011; addr[7:0] = 8'h20; addr[15:8] = 8'h21;
    push(3'b001, 32'd7, c0 + 2);
    push(3'b010, 32'd7, c0 + 5);
    step();
    chk("wrap_first_addr", 32'(sram_addr), 32'h20);
    step();
    req[0] = 1'b0;
    step();
    step();
    chk("wrap_second_addr", 32'(sram_addr), 32'h21);
    step();
    req = '0;
    step();

    // Dropped request: requester 2 read, req released in the issue cycle
    c0 = cyc;
    req = 3'b100; we = 3'b000; addr[23:16] = 8'h33;
    push(3'b100, 32'h55, c0 + 4);
    step();
    req = '0;
    chk("drop_issue_addr", 32'(sram_addr), 32'h33);
    step();
    step();
    sram_rdata = 32'h55;
    step();
    sram_rdata = 32'd0;
    step();
    step();
    step();
    chk("drop_idle_gnt", 32'(gnt), 32'd0);
    chk("drop_idle_en", 32'(sram_en), 32'd0);

    // Reset in the middle of a read: abandoned, no done pulse
    c0 = cyc;
    req = 3'b100; we = 3'b000; addr[23:16] = 8'h44;
    step();
    step();
    rst = 1'b1;
    req = '0;
    step();
    chk("midrst_gnt", 32'(gnt), 32'd0);
    chk("midrst_done", 32'(done), 32'd0);
    chk("midrst_rdata", rdata, 32'd0);
    chk("midrst_sram_en", 32'(sram_en), 32'd0);
    chk("midrst_sram_we", 32'(sram_we), 32'd0);
    chk("midrst_sram_addr", 32'(sram_addr), 32'd0);
    chk("midrst_sram_wdata", sram_wdata, 32'd0);
    rst = 1'b0;
    c1 = cyc;
    req = 3'b010; we = 3'b010; addr[15:8] = 8'h55; wdata[63:32] = 32'h99;
    push(3'b010, 32'd0, c1 + 2);
    step();
    chk("midrst_next_gnt", 32'(gnt), 32'b010);
    chk("midrst_next_wdata", sram_wdata, 32'h99);
    step();
    req = '0;
    step();
    step();

    // Contention from reset: all three writing, req held throughout
    rst = 1'b1;
    step();
    step();
    rst = 1'b0;
    c0 = cyc;
    req = 3'b111; we = 3'b111;
    addr[7:0] = 8'h10; addr[15:8] = 8'h11; addr[23:16] = 8'h12;
    for (int i = 0; i < 4; i++) begin
      int w;
`ifdef T05_ARB_FIXED_PRIO_EN
      w = 0;
`else
      w = i % 3;
`endif
      push(3'(1) << w, 32'd0, c0 + 2 + 3 * i);
    end
    repeat (11) step();
    req = '0;
    repeat (3) step();
    chk("cont_final_gnt", 32'(gnt), 32'd0);
    step();
    chk("all_done_seen", 32'(exp_q.size()), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
